// File: rtl/gin_write_arbiter.sv
// gin_write_arbiter: round-robin burst arbiter that funnels ifmap/filter/psum beats into
// the GIN tag and data FIFOs, holding the grant from the first beat until req_last.
module gin_write_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [0:NUM_OF_REQ-1]         req_valid,
  input  logic [0:NUM_OF_REQ-1]         req_last,
  input  logic [ROW_TAG_WIDTH-1:0]      req_row_tag [0:NUM_OF_REQ-1],
  input  logic [COL_TAG_WIDTH-1:0]      req_col_tag [0:NUM_OF_REQ-1],
  input  logic [DATA_WIDTH-1:0]         req_data    [0:NUM_OF_REQ-1],
  output logic [0:NUM_OF_REQ-1]         req_ready,
  output logic [ROW_TAG_WIDTH-1:0]      row_tag,
  output logic [COL_TAG_WIDTH-1:0]      col_tag,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          tags_wr_en,
  output logic                          data_wr_en,
  input  logic                          tags_full,
  input  logic                          data_full,
  output logic [$clog2(NUM_OF_REQ)-1:0] grant_id,
  output logic                          busy,
  output logic [31:0]                   beat_count
);
  localparam int GW = $clog2(NUM_OF_REQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] last_q, pick, idx;
  logic [31:0] cnt_q;
  logic fire;
  // descending scan so the nearest valid requester after last_q is the final assignment
  always_comb begin
    pick = last_q;
    idx = '0;
    for (int i = NUM_OF_REQ; i >= 1; i--) begin
      idx = GW'((int'(last_q) + i) % NUM_OF_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  assign busy       = state_q == BURST;
  assign fire       = busy & req_valid[grant_id] & ~tags_full & ~data_full;
  assign tags_wr_en = fire;
  assign data_wr_en = fire;
  assign row_tag    = busy ? req_row_tag[grant_id] : '0;
  assign col_tag    = busy ? req_col_tag[grant_id] : '0;
  assign data_out   = busy ? req_data[grant_id] : '0;
  assign beat_count = cnt_q;
  always_comb begin
    req_ready = '0;
    req_ready[grant_id] = fire;
  end
  always_comb state_d = busy ? ((fire && req_last[grant_id]) ? IDLE : BURST) : (|req_valid ? BURST : IDLE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_id <= '0;
      last_q   <= GW'(NUM_OF_REQ - 1);
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!busy && |req_valid) begin
        grant_id <= pick;
        last_q   <= pick;
      end
      if (fire) cnt_q <= cnt_q + 32'd1;
    end
  end
endmodule
